// File: rtl/sseg_scan_mux_if.sv
// ============================================================================
// Module   : sseg_scan_mux_if
// Brief    : Control/value inputs and scan outputs of the 7-segment scan mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sseg_scan_mux_if #(
  parameter int DIGITS = 4
);
  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  en;
  logic [4*DIGITS-1:0]   value;
  logic                  load;
  logic                  blank_lz;
  logic [3:0]            nibble;
  logic                  seg_oe;
  logic [DIGITS-1:0]     digit_en;
  logic [c_IDX_W-1:0]    digit_idx;
  logic                  frame_done;

  modport master (
    output en, value, load, blank_lz,
    input  nibble, seg_oe, digit_en, digit_idx, frame_done
  );

  modport slave (
    input  en, value, load, blank_lz,
    output nibble, seg_oe, digit_en, digit_idx, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/sseg_scan_mux.sv
// ============================================================================
// Module   : sseg_scan_mux
// Brief    : Time-multiplexed digit scanner feeding a 7-segment decoder, with
//            dead time, leading-zero blanking and frame-aligned value updates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int CLK_DIV     = 1000,
  parameter int DEAD_CYCLES = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  sseg_scan_mux_if.slave   bus
);

  localparam int c_PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_VW = 4 * DIGITS;

  localparam logic [c_PW-1:0] c_P_LAST = c_PW'(CLK_DIV - 1);
  localparam logic [c_PW-1:0] c_P_DEAD = c_PW'(DEAD_CYCLES);
  localparam logic [c_DW-1:0] c_D_LAST = c_DW'(DIGITS - 1);

  logic [c_PW-1:0]   r_p;
  logic [c_DW-1:0]   r_d;
  logic [c_VW-1:0]   r_a;
  logic [c_VW-1:0]   r_pend;
  logic              r_pv;

  logic [3:0]        r_nibble;
  logic              r_seg_oe;
  logic [DIGITS-1:0] r_digit_en;
  logic [c_DW-1:0]   r_digit_idx;
  logic              r_frame_done;

  logic              w_tick;
  logic              w_wrap;
  logic              w_live;
  logic              w_upper_zero;
  logic              w_blank;
  logic [3:0]        w_nibble;
  logic [DIGITS-1:0] w_onehot;

  assign w_tick = bus.en && (r_p == c_P_LAST);
  assign w_wrap = w_tick && (r_d == c_D_LAST);
  assign w_live = (r_p >= c_P_DEAD);

  always_comb begin
    w_nibble     = 4'h0;
    w_onehot     = '0;
    w_upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_d == c_DW'(i)) begin
        w_nibble    = r_a[4*i +: 4];
        w_onehot[i] = 1'b1;
      end
      // Any nonzero nibble at or above the current digit keeps it visible.
      if ((c_DW'(i) >= r_d) && (r_a[4*i +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  assign w_blank = bus.blank_lz && (r_d != '0) && w_upper_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p          <= '0;
      r_d          <= '0;
      r_a          <= '0;
      r_pend       <= '0;
      r_pv         <= 1'b0;
      r_nibble     <= 4'h0;
      r_seg_oe     <= 1'b0;
      r_digit_en   <= '0;
      r_digit_idx  <= '0;
      r_frame_done <= 1'b0;
    end else if (!bus.en) begin
      r_p          <= '0;
      r_d          <= '0;
      r_nibble     <= 4'h0;
      r_seg_oe     <= 1'b0;
      r_digit_en   <= '0;
      r_digit_idx  <= '0;
      r_frame_done <= 1'b0;
      // Idle display: no tearing possible, so load goes straight to A.
      if (bus.load) begin
        r_a  <= bus.value;
        r_pv <= 1'b0;
      end
    end else begin
      if (w_tick) begin
        r_p <= '0;
        r_d <= (r_d == c_D_LAST) ? '0 : r_d + 1'b1;
      end else begin
        r_p <= r_p + 1'b1;
      end

      if (w_wrap) begin
        r_a  <= bus.load ? bus.value : (r_pv ? r_pend : r_a);
        r_pv <= 1'b0;
      end else if (bus.load) begin
        r_pend <= bus.value;
        r_pv   <= 1'b1;
      end

      r_digit_idx  <= r_d;
      r_nibble     <= w_nibble;
      r_digit_en   <= w_live ? w_onehot : '0;
      r_seg_oe     <= w_live && !w_blank;
      r_frame_done <= w_wrap;
    end
  end

  assign bus.nibble     = r_nibble;
  assign bus.seg_oe     = r_seg_oe;
  assign bus.digit_en   = r_digit_en;
  assign bus.digit_idx  = r_digit_idx;
  assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
- Upstream driver for the sseg 7-segment decoder in a multiplexed multi-digit display.
- Holds a packed multi-nibble value and time-slices it one digit at a time onto the decoder's 4-bit `in` and its `oe`.
- Drives a one-hot digit-select bus for the common anodes/cathodes, with dead time between digits against ghosting, optional leading-zero blanking, and tear-free value updates at frame boundaries.

Parameters:
- DIGITS, 4: number of multiplexed digits; must be >= 1.
- CLK_DIV, 1000: clock cycles per digit slot; must be >= DEAD_CYCLES+1.
- DEAD_CYCLES, 2: cycles at the start of each slot where all digit selects are off.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- value  in  4*DIGITS  packed nibbles; digit i at [4i+3:4i], digit 0 is least significant.
- load  in  1  capture `value` this cycle.
- blank_lz  in  1  enable leading-zero suppression.
- nibble  out  4  digit code to sseg `in`.
- seg_oe  out  1  to sseg `oe`.
- digit_en  out  DIGITS  one-hot active-high digit select.
- digit_idx  out  clog2(DIGITS) (min 1)  current digit index.
- frame_done  out  1  one-cycle pulse on frame wrap.

Behaviour:
- Internal state:
  - prescaler p, range 0..CLK_DIV-1.
  - digit index d, range 0..DIGITS-1.
  - active register A and pending register P, each 4*DIGITS wide.
  - pending_valid flag pv.
- Reset (rst_n low, no clock needed): p, d, A, P, pv cleared. All outputs 0 immediately: nibble=0, seg_oe=0, digit_en=0, digit_idx=0, frame_done=0.
- en=0:
  - p and d are held at 0.
  - digit_en, seg_oe and frame_done are registered to 0.
  - load writes A directly and clears pv.
- en=1, each cycle:
  - If p==CLK_DIV-1: p<=0 and d<=(d==DIGITS-1)?0:d+1. Otherwise p<=p+1.
- Frame wrap is the tick with d==DIGITS-1 (for DIGITS=1, every tick). On a wrap:
  - A <= load ? value : (pv ? P : A).
  - pv <= 0.
  - frame_done is registered high for exactly one cycle.
- load while en=1 and not at a wrap: P<=value, pv<=1. A later load before the wrap overwrites P; last write wins.
- Outputs are registered from the current (p,d,A) with 1-cycle latency:
  - digit_idx = d.
  - nibble = A[4d+3:4d].
  - digit_en = one-hot(d) when p>=DEAD_CYCLES, else all zero.
  - seg_oe = (p>=DEAD_CYCLES) && !blank(d).
- blank(d) = blank_lz && d!=0 && every nibble of A from index d up to DIGITS-1 is 0. Digit 0 is never blanked; a value of 0 shows a single "0".
- Blanked digits still assert digit_en with seg_oe=0, so the sseg decoder output is released.
- en falling mid-frame:
  - Next cycle, outputs go 0 and p and d go to 0.
  - A is unchanged; pv and P are retained.
  - Re-enable restarts at digit 0, p=0. The pending value is applied at the first wrap.
- Reset asserted mid-scan: immediate return to reset state; no partial frame completes.
- Invariants:
  - digit_en is never multi-hot.
  - At most one frame_done per DIGITS*CLK_DIV cycles while en=1.

Test Plan (DIGITS=4, CLK_DIV=8, DEAD_CYCLES=2 unless noted):
1. rst_n=0 with random inputs, no clock edges -> nibble=0, seg_oe=0, digit_en=4'b0000, digit_idx=0, frame_done=0; all hold 0 through 5 clocks of reset.
2. en=0, load value=16'h1234, then en=1 -> per 8-cycle slot: 2 cycles digit_en=0000, then 6 cycles of 0001/nibble=4, 0010/3, 0100/2, 1000/1; seg_oe=1 while digit_en!=0; frame_done pulses every 32 cycles.
3. Leading zeros, A=16'h0045, blank_lz=1 -> digits 2 and 3 show digit_en asserted with seg_oe=0; digits 0 and 1 show 5 and 4. A=16'h0000 -> only digit 0 has seg_oe=1, nibble 0. Repeat with blank_lz=0 -> all four seg_oe=1.
4. While scanning 16'h1234, load 16'hABCD at digit 1 -> rest of frame still shows 3, 2, 1; next frame shows D, C, B, A. Second case: load 16'h5555 coincident with wrap tick -> next frame shows 5s with no 1234 frame between.
5. Async reset mid-scan: rst_n low during digit 2, p=5, between clock edges -> outputs 0 in the same delta, not on the next edge. After release with en=1, scan restarts at digit 0, showing 0 with blanking off.
6. en low at digit 2, then high after 10 cycles with a load issued while en=0 -> outputs 0 while low; on re-enable the loaded value shows from digit 0, p=0; no spurious frame_done.
